// File: rtl/mem_loader.sv
// Streams bytes into a single-port RAM from address 0 and keeps a 16-bit checksum.
// Define MEM_LOADER_VERIFY_EN to build the read-back pass and checksum compare.
module mem_loader #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       wr_sum,
  output logic [15:0]       rd_sum
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_DONE = 3'd4;
`ifdef MEM_LOADER_VERIFY_EN
  localparam logic [2:0] S_VERIFY = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [RD_LAT-1:0] PIPE_LAST = RD_LAT'(1'b1) << (RD_LAT - 1);
`endif

  localparam logic [ADDR_W:0] LEN_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0] LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] DEPTH    = {1'b1, {ADDR_W{1'b0}}};

  logic [2:0]        state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [15:0]       wr_sum_q, wr_sum_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [ADDR_W:0]   len_clamped_s;
  logic              hs_s;
  logic              last_beat_s;

`ifdef MEM_LOADER_VERIFY_EN
  logic [15:0]       rd_sum_q, rd_sum_d;
  logic              error_q, error_d;
  logic              rd_issue_q, rd_issue_d;
  logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
  logic [RD_LAT-1:0] early_s;
  logic              drain_done_s;

  // Reads still in flight other than the one landing this cycle hold DRAIN open.
  assign early_s      = rd_pipe_q & ~PIPE_LAST;
  assign drain_done_s = !rd_issue_q && (early_s == {RD_LAT{1'b0}});
`else
  logic unused_s;
  assign unused_s = ^{mem_rdata, 1'(RD_LAT)};
`endif

  assign len_clamped_s = (len > DEPTH) ? DEPTH : len;
  assign s_ready       = (state_q == S_LOAD);
  assign hs_s          = s_valid & s_ready;
  assign last_beat_s   = (ptr_q == (len_q - LEN_ONE));

  // Next-state, write path and checksum decode.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    ptr_d       = ptr_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wr_sum_d    = wr_sum_q;
`ifdef MEM_LOADER_VERIFY_EN
    error_d     = error_q;
    rd_issue_d  = 1'b0;
    rd_pipe_d   = (rd_pipe_q << 1'b1) | RD_LAT'(rd_issue_q);
    if (rd_pipe_q[RD_LAT-1]) begin
      rd_sum_d = rd_sum_q + 16'(mem_rdata);
    end else begin
      rd_sum_d = rd_sum_q;
    end
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          len_d    = len_clamped_s;
          ptr_d    = LEN_ZERO;
          wr_sum_d = 16'h0000;
`ifdef MEM_LOADER_VERIFY_EN
          rd_sum_d = 16'h0000;
          error_d  = 1'b0;
`endif
          if (len_clamped_s == LEN_ZERO) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_LOAD: begin
        if (hs_s) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = ptr_q[ADDR_W-1:0];
          mem_wdata_d = s_data;
          wr_sum_d    = wr_sum_q + 16'(s_data);
          // A full-depth load wraps the pointer here instead of issuing another write.
          if (last_beat_s) begin
            ptr_d = LEN_ZERO;
`ifdef MEM_LOADER_VERIFY_EN
            state_d = S_VERIFY;
`else
            state_d = S_DONE;
`endif
          end else begin
            ptr_d = ptr_q + LEN_ONE;
          end
        end else begin
          mem_we_d = 1'b0;
        end
      end
`ifdef MEM_LOADER_VERIFY_EN
      S_VERIFY: begin
        if (ptr_q != len_q) begin
          mem_addr_d = ptr_q[ADDR_W-1:0];
          rd_issue_d = 1'b1;
          ptr_d      = ptr_q + LEN_ONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_done_s) begin
          state_d = S_DONE;
          error_d = (wr_sum_q != rd_sum_d);
        end else begin
          state_d = S_DRAIN;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
`ifdef MEM_LOADER_VERIFY_EN
    busy_d = (state_d == S_LOAD) || (state_d == S_VERIFY) || (state_d == S_DRAIN);
`else
    busy_d = (state_d == S_LOAD);
`endif
    done_d = (state_d == S_DONE);
  end

  // Core state and write-side registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= LEN_ZERO;
      ptr_q       <= LEN_ZERO;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      wr_sum_q    <= 16'h0000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      ptr_q       <= ptr_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wr_sum_q    <= wr_sum_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef MEM_LOADER_VERIFY_EN
  // Read-back tagging pipeline and compare result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_sum_q   <= 16'h0000;
      error_q    <= 1'b0;
      rd_issue_q <= 1'b0;
      rd_pipe_q  <= {RD_LAT{1'b0}};
    end else begin
      rd_sum_q   <= rd_sum_d;
      error_q    <= error_d;
      rd_issue_q <= rd_issue_d;
      rd_pipe_q  <= rd_pipe_d;
    end
  end

  assign rd_sum = rd_sum_q;
  assign error  = error_q;
`else
  assign rd_sum = 16'h0000;
  assign error  = 1'b0;
`endif

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wr_sum    = wr_sum_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed, table-driven bench for mem_loader; runs RD_LAT=1 and RD_LAT=3 instances side by side.
module tb_mem_loader;

`ifdef MEM_LOADER_VERIFY_EN
  localparam bit VERIFY_ON = 1'b1;
`else
  localparam bit VERIFY_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, start, s_valid;
  logic [7:0] len, s_data;

  logic       s_ready1, mem_we1, busy1, done1, error1;
  logic [6:0] mem_addr1;
  logic [7:0] mem_wdata1, rdata1;
  logic [15:0] wr_sum1, rd_sum1;

  logic       s_ready3, mem_we3, busy3, done3, error3;
  logic [6:0] mem_addr3;
  logic [7:0] mem_wdata3, rdata3, p3a, p3b;
  logic [15:0] wr_sum3, rd_sum3;

  logic [7:0] mem1 [128];
  logic [7:0] mem3 [128];

  int n_vec = 0;
  int n_fail = 0;
  int corrupt_addr = -1;
  int wr_cnt1 = 0;
  int wr_cnt3 = 0;
  int mon_err1 = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  mem_loader #(.ADDR_W(7), .DATA_W(8), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(rdata1), .busy(busy1), .done(done1), .error(error1), .wr_sum(wr_sum1), .rd_sum(rd_sum1)
  );

  mem_loader #(.ADDR_W(7), .DATA_W(8), .RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(rdata3), .busy(busy3), .done(done3), .error(error3), .wr_sum(wr_sum3), .rd_sum(rd_sum3)
  );

  function automatic logic [7:0] corrupt_mask(input logic [6:0] a);
    return (int'(a) == corrupt_addr) ? 8'h01 : 8'h00;
  endfunction

  // Memory models: latency 1 and latency 3, with optional single-address corruption on read.
  always @(posedge clk) begin
    if (mem_we1) mem1[mem_addr1] <= mem_wdata1;
    rdata1 <= mem1[mem_addr1] ^ corrupt_mask(mem_addr1);
    if (mem_we3) mem3[mem_addr3] <= mem_wdata3;
    p3a    <= mem3[mem_addr3] ^ corrupt_mask(mem_addr3);
    p3b    <= p3a;
    rdata3 <= p3b;
  end

  // Write monitor: each handshake must produce exactly one write, one cycle later, at the next address.
  logic [7:0] exp_data_q [$];
  logic [6:0] exp_addr_q [$];
  logic [6:0] wr_ptr = 7'd0;
  bit         prev_hs1 = 1'b0;
  initial forever begin
    @(posedge clk);
    if (mon_en) begin
      if (mem_we1 !== prev_hs1) mon_err1++;
      if (mem_we1 === 1'b1) begin
        wr_cnt1++;
        if (exp_data_q.size() == 0) begin
          mon_err1++;
        end else begin
          if (mem_wdata1 !== exp_data_q[0] || mem_addr1 !== exp_addr_q[0]) mon_err1++;
          void'(exp_data_q.pop_front());
          void'(exp_addr_q.pop_front());
        end
      end
      if (mem_we3 === 1'b1) wr_cnt3++;
      if (rst_n && start && !busy1) wr_ptr = 7'd0;
      prev_hs1 = rst_n && s_valid && s_ready1;
      if (prev_hs1) begin
        exp_data_q.push_back(s_data);
        exp_addr_q.push_back(wr_ptr);
        wr_ptr = wr_ptr + 7'd1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [7:0]  len;
    int          beats;
    bit          by_index;
    logic [63:0] dlist;
    logic [7:0]  vmask;
    int          corrupt;
    int          inj;
    logic [15:0] exp_wr;
    logic [15:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vecs [10];

  task automatic set_vec(input int i, input string name, input logic [7:0] l, input int beats,
                         input bit by_index, input logic [63:0] dlist, input logic [7:0] vmask,
                         input int corrupt, input int inj, input logic [15:0] exp_wr,
                         input logic [15:0] exp_rd, input bit exp_err);
    vecs[i].name = name;       vecs[i].len = l;          vecs[i].beats = beats;
    vecs[i].by_index = by_index; vecs[i].dlist = dlist;  vecs[i].vmask = vmask;
    vecs[i].corrupt = corrupt; vecs[i].inj = inj;        vecs[i].exp_wr = exp_wr;
    vecs[i].exp_rd = exp_rd;   vecs[i].exp_err = exp_err;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int beat, cyc, lat1, lat3, len_eff, w1, w3, m1;
    logic hs;
    v = vecs[i];
    len_eff = (int'(v.len) > 128) ? 128 : int'(v.len);
    corrupt_addr = v.corrupt;
    w1 = wr_cnt1; w3 = wr_cnt3; m1 = mon_err1;
    start = 1'b1; len = v.len; s_valid = 1'b0;
    tick();
    start = 1'b0; len = 8'd0;
    if (len_eff == 0) begin
      check({v.name, "_done_next"}, 32'(done1), 32'd1);
    end else begin
      check({v.name, "_done_fall"}, 32'({done1, busy1}), 32'b01);
    end
    beat = 0; cyc = 0;
    while (beat < v.beats && cyc < 4000) begin
      s_valid = v.vmask[cyc % 8];
      s_data  = v.by_index ? 8'(beat) : v.dlist[beat*8 +: 8];
      if (v.inj == 1 && beat == 2) begin
        start = 1'b1; len = 8'd2;
      end else begin
        start = 1'b0; len = 8'd0;
      end
      hs = s_valid & s_ready1;
      tick();
      if (hs) beat++;
      cyc++;
    end
    s_valid = 1'b0; start = 1'b0; len = 8'd0;
    check({v.name, "_beats"}, 32'(beat), 32'(v.beats));
    lat1 = done1 ? 0 : -1;
    lat3 = done3 ? 0 : -1;
    cyc = 0;
    while ((lat1 < 0 || lat3 < 0) && cyc < 1000) begin
      if (v.inj == 2 && VERIFY_ON && cyc == 0) begin
        start = 1'b1; len = 8'd2;
      end else begin
        start = 1'b0; len = 8'd0;
      end
      tick();
      cyc++;
      if (lat1 < 0 && done1) lat1 = cyc;
      if (lat3 < 0 && done3) lat3 = cyc;
    end
    start = 1'b0; len = 8'd0;
    tick();
    check({v.name, "_wr_sum"},  32'(wr_sum1), 32'(v.exp_wr));
    check({v.name, "_wr_sum3"}, 32'(wr_sum3), 32'(v.exp_wr));
    check({v.name, "_rd_sum"},  32'(rd_sum1), 32'(VERIFY_ON ? v.exp_rd : 16'h0000));
    check({v.name, "_rd_sum3"}, 32'(rd_sum3), 32'(VERIFY_ON ? v.exp_rd : 16'h0000));
    check({v.name, "_error"},   32'(error1),  32'(VERIFY_ON ? v.exp_err : 1'b0));
    check({v.name, "_error3"},  32'(error3),  32'(VERIFY_ON ? v.exp_err : 1'b0));
    check({v.name, "_writes"},  32'(wr_cnt1 - w1), 32'(len_eff));
    check({v.name, "_writes3"}, 32'(wr_cnt3 - w3), 32'(len_eff));
    check({v.name, "_wrseq"},   32'(mon_err1 - m1), 32'd0);
    check({v.name, "_final"},   32'({done1, busy1, mem_we1, done3, busy3}), 32'b10010);
    if (len_eff > 0) begin
      check({v.name, "_lat1"}, 32'(lat1), VERIFY_ON ? 32'(len_eff + 2) : 32'd0);
      check({v.name, "_lat3"}, 32'(lat3), VERIFY_ON ? 32'(len_eff + 4) : 32'd0);
      check({v.name, "_addr"}, 32'(mem_addr1), 32'(len_eff - 1));
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = 8'd0; s_valid = 1'b0; s_data = 8'd0;

    set_vec(0, "len4",     8'd4,   4,   1'b0, 64'h0000_0000_4433_2211, 8'hFF, -1, 0, 16'h00AA, 16'h00AA, 1'b0);
    set_vec(1, "len128",   8'd128, 128, 1'b1, 64'h0,                   8'hFF, -1, 0, 16'h1FC0, 16'h1FC0, 1'b0);
    set_vec(2, "len0",     8'd0,   0,   1'b0, 64'h0,                   8'hFF, -1, 0, 16'h0000, 16'h0000, 1'b0);
    set_vec(3, "gaps",     8'd2,   2,   1'b0, 64'h0000_0000_0000_01FF, 8'hF9, -1, 0, 16'h0100, 16'h0100, 1'b0);
    set_vec(4, "corrupt5", 8'd8,   8,   1'b0, 64'h0706_0504_0302_0100, 8'hFF,  5, 0, 16'h001C, 16'h001B, 1'b1);
    set_vec(5, "corrupt4", 8'd8,   8,   1'b0, 64'h0706_0504_0302_0100, 8'hFF,  4, 0, 16'h001C, 16'h001D, 1'b1);
    set_vec(6, "clamp200", 8'd200, 128, 1'b1, 64'h0,                   8'hFF, -1, 0, 16'h1FC0, 16'h1FC0, 1'b0);
    set_vec(7, "len1",     8'd1,   1,   1'b0, 64'h0000_0000_0000_00A5, 8'hFF, -1, 0, 16'h00A5, 16'h00A5, 1'b0);
    set_vec(8, "start_in_load",   8'd4, 4, 1'b0, 64'h0000_0000_0403_0201, 8'hFF, -1, 1, 16'h000A, 16'h000A, 1'b0);
    set_vec(9, "start_in_verify", 8'd4, 4, 1'b0, 64'h0000_0000_0403_0201, 8'hFF, -1, 2, 16'h000A, 16'h000A, 1'b0);

    // Reset state.
    repeat (3) tick();
    check("reset_ctrl", 32'({s_ready1, mem_we1, busy1, done1, error1}), 32'd0);
    check("reset_addr_data", 32'({mem_addr1, mem_wdata1}), 32'd0);
    check("reset_sums", 32'({wr_sum1, rd_sum1}), 32'd0);
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;

    // len=0 from IDLE: straight to DONE, no memory traffic.
    start = 1'b1; len = 8'd0;
    tick();
    start = 1'b0;
    check("len0_idle_done", 32'({done1, busy1, mem_we1, error1}), 32'b1000);
    check("len0_idle_sums", 32'({wr_sum1, rd_sum1}), 32'd0);
    check("len0_idle_done3", 32'(done3), 32'd1);

    for (int i = 0; i < 10; i++) begin
      run_vec(i);
    end

    // Reset in the middle of LOAD after three beats.
    corrupt_addr = -1;
    start = 1'b1; len = 8'd8;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1; s_data = 8'h10 + 8'(k);
      tick();
    end
    check("midrst_wr_sum_before", 32'(wr_sum1), 32'h33);
    begin
      int w1;
      w1 = wr_cnt1;
      rst_n = 1'b0;
      tick();
      check("midrst_ctrl", 32'({s_ready1, mem_we1, busy1, done1, error1}), 32'd0);
      check("midrst_sums", 32'({wr_sum1, rd_sum1}), 32'd0);
      rst_n = 1'b1;
      repeat (3) tick();
      check("midrst_no_more_writes", 32'(wr_cnt1 - w1), 32'd1);
      check("midrst_idle", 32'({s_ready1, busy1, done1}), 32'd0);
    end
    s_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
